decode_stage_pipe: RTL and testbench

Parametrised successor to the decode stage. Decodes an RV32I/RV32E instruction and reads a parametrised register file with writeback bypass. Generates all immediate formats, including U-type. Registers the results into an ID/EX pipeline register that supports stall (hold) and flush (bubble). It sits between the fetch stage and the execute stage, and receives the writeback port from the writeback stage.

---
 rtl/decode_stage_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// RV32I/RV32E decode stage: instruction decode, register file with writeback
// bypass, immediate generation and the ID/EX pipeline register (stall/flush).
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      InstrD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic             ValidD,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             RegWriteW,
  input  logic [4:0]       RDW,
  input  logic [XLEN-1:0]  ResultW,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             ALUSrcE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             IllegalE,
  output logic [1:0]       ResultSrcE,
  output logic [ALUCW-1:0] ALUControlE,
  output logic [XLEN-1:0]  RD1_E,
  output logic [XLEN-1:0]  RD2_E,
  output logic [XLEN-1:0]  Imm_Ext_E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       RS1_E,
  output logic [4:0]       RS2_E,
  output logic [4:0]       RD_E
);

  localparam int         IDXW   = $clog2(NREG);
  localparam logic [5:0] NREG_L = 6'(NREG);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [ALUCW-1:0] ALU_ADD   = ALUCW'(0);
  localparam logic [ALUCW-1:0] ALU_SUB   = ALUCW'(1);
  localparam logic [ALUCW-1:0] ALU_AND   = ALUCW'(2);
  localparam logic [ALUCW-1:0] ALU_OR    = ALUCW'(3);
  localparam logic [ALUCW-1:0] ALU_XOR   = ALUCW'(4);
  localparam logic [ALUCW-1:0] ALU_SLT   = ALUCW'(5);
  localparam logic [ALUCW-1:0] ALU_SLL   = ALUCW'(6);
  localparam logic [ALUCW-1:0] ALU_SRL   = ALUCW'(7);
  localparam logic [ALUCW-1:0] ALU_SRA   = ALUCW'(8);
  localparam logic [ALUCW-1:0] ALU_PASSB = ALUCW'(9);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             alu_src;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             illegal;
    logic [1:0]       result_src;
    logic [ALUCW-1:0] alu_ctrl;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc4;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
  } idex_t;

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < NREG_L;
  endfunction

  // sub_ok: only R-type uses funct7[5] to pick SUB; I-type only for SRAI.
  // SLTU has no dedicated encoding and shares the SLT code.
  function automatic logic [ALUCW-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                              input logic sub_ok);
    case (f3)
      3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  logic [4:0]      rs1, rs2, rd;
  logic            wb_en;
  logic [XLEN-1:0] rd1, rd2;
  logic [XLEN-1:0] regs [NREG];

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign f7b5   = InstrD[30];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign rd     = InstrD[11:7];
  assign wb_en  = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && in_range(RDW)) begin
      regs[RDW[IDXW-1:0]] <= ResultW;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (wb_en && RDW == rs1)               rd1 = ResultW;
    else if (rs1 != 5'd0 && in_range(rs1)) rd1 = regs[rs1[IDXW-1:0]];
    if (wb_en && RDW == rs2)               rd2 = ResultW;
    else if (rs2 != 5'd0 && in_range(rs2)) rd2 = regs[rs2[IDXW-1:0]];
  end

  idex_t       dec, q;
  logic        known, use_rs1, use_rs2, use_rd;
  logic [31:0] imm32;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.pc    = PCD;
    dec.pc4   = PCPlus4D;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.rd    = rd;
    dec.rd1   = rd1;
    dec.rd2   = rd2;
    known     = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    imm32     = {{20{InstrD[31]}}, InstrD[31:20]};
    case (opcode)
      OP_LOAD: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1; dec.alu_src = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R: begin
        dec.reg_write = 1'b1; dec.alu_ctrl = alu_op(funct3, f7b5, 1'b1);
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_ctrl = alu_op(funct3, f7b5, 1'b0);
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1; dec.alu_ctrl = ALU_SUB;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.result_src = 2'b10;
        use_rd = 1'b1;
        imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = ALU_PASSB;
        use_rd = 1'b1;
        imm32 = {InstrD[31:12], 12'b0};
      end
      default: known = 1'b0;
    endcase
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = !known || (use_rs1 && !in_range(rs1)) ||
                  (use_rs2 && !in_range(rs2)) || (use_rd && !in_range(rd));
    // An illegal instruction still travels down the pipe but must not side-effect.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  // Bubbles are all-zero; a held entry keeps its operands even if writeback
  // later updates its source registers (the forwarding unit covers that).
  always_ff @(posedge clk) begin
    if (rst)          q <= '0;
    else if (FlushE)  q <= '0;
    else if (!StallD) q <= ValidD ? dec : '0;
  end

  assign ValidE      = q.valid;
  assign RegWriteE   = q.reg_write;
  assign ALUSrcE     = q.alu_src;
  assign MemWriteE   = q.mem_write;
  assign BranchE     = q.branch;
  assign JumpE       = q.jump;
  assign IllegalE    = q.illegal;
  assign ResultSrcE  = q.result_src;
  assign ALUControlE = q.alu_ctrl;
  assign RD1_E       = q.rd1;
  assign RD2_E       = q.rd2;
  assign Imm_Ext_E   = q.imm;
  assign PCE         = q.pc;
  assign PCPlus4E    = q.pc4;
  assign RS1_E       = q.rs1;
  assign RS2_E       = q.rs2;
  assign RD_E        = q.rd;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: an RV32I instance and an RV32E
// instance share the same stimulus.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        ValidD, StallD, FlushE, RegWriteW;
  logic [4:0]  RDW;

  logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RS1_E, RS2_E, RD_E;

  logic        e_ValidE, e_RegWriteE, e_ALUSrcE, e_MemWriteE, e_BranchE, e_JumpE, e_IllegalE;
  logic [1:0]  e_ResultSrcE;
  logic [3:0]  e_ALUControlE;
  logic [31:0] e_RD1_E, e_RD2_E, e_Imm_Ext_E, e_PCE, e_PCPlus4E;
  logic [4:0]  e_RS1_E, e_RS2_E, e_RD_E;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(32), .NREG(32), .ALUCW(4)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW),
    .RDW(RDW), .ResultW(ResultW),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
  );

  decode_stage_pipe #(.XLEN(32), .NREG(16), .ALUCW(4)) dut_e (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW),
    .RDW(RDW), .ResultW(ResultW),
    .ValidE(e_ValidE), .RegWriteE(e_RegWriteE), .ALUSrcE(e_ALUSrcE), .MemWriteE(e_MemWriteE),
    .BranchE(e_BranchE), .JumpE(e_JumpE), .IllegalE(e_IllegalE), .ResultSrcE(e_ResultSrcE),
    .ALUControlE(e_ALUControlE), .RD1_E(e_RD1_E), .RD2_E(e_RD2_E), .Imm_Ext_E(e_Imm_Ext_E),
    .PCE(e_PCE), .PCPlus4E(e_PCPlus4E), .RS1_E(e_RS1_E), .RS2_E(e_RS2_E), .RD_E(e_RD_E)
  );

  // {Valid, RegWrite, MemWrite, Branch, Jump, Illegal}
  logic [5:0]   flg, e_flg;
  logic [187:0] all_out, e_all_out;
  assign flg   = {ValidE, RegWriteE, MemWriteE, BranchE, JumpE, IllegalE};
  assign e_flg = {e_ValidE, e_RegWriteE, e_MemWriteE, e_BranchE, e_JumpE, e_IllegalE};
  assign all_out = {ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE,
                    ResultSrcE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
                    RS1_E, RS2_E, RD_E};
  assign e_all_out = {e_ValidE, e_RegWriteE, e_ALUSrcE, e_MemWriteE, e_BranchE, e_JumpE,
                      e_IllegalE, e_ResultSrcE, e_ALUControlE, e_RD1_E, e_RD2_E, e_Imm_Ext_E,
                      e_PCE, e_PCPlus4E, e_RS1_E, e_RS2_E, e_RD_E};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    ValidD = 1'b0; RegWriteW = 1'b1; RDW = r; ResultW = v;
    step();
    RegWriteW = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; ValidD = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; StallD = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0;
    wb(5'd5, 32'hCAFEF00D);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom; ResultW = $urandom;
      RDW = 5'($urandom); ValidD = 1'b1; RegWriteW = 1'b1;
      StallD = 1'($urandom); FlushE = 1'($urandom);
      step();
      if (all_out !== '0) begin $display("FAIL reset_outputs got %h exp 0", all_out); n_fail++; end
      n_tests++;
      if (e_all_out !== '0) begin $display("FAIL reset_outputs_e got %h exp 0", e_all_out); n_fail++; end
      n_tests++;
    end
    rst = 1'b0; RegWriteW = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    issue(32'h000283B3, 32'h40);
    if (RD1_E !== 32'h0) begin $display("FAIL reset_reg_x5 got %h exp 0", RD1_E); n_fail++; end
    n_tests++;
    if (flg !== 6'b110000) begin $display("FAIL reset_first_flags got %b exp 110000", flg); n_fail++; end
    n_tests++;
  endtask

  task automatic test_write_read();
    wb(5'd5, 32'h12345678);
    issue(32'h000283B3, 32'h100);
    if (RD1_E !== 32'h12345678) begin $display("FAIL wr_rd1 got %h exp 12345678", RD1_E); n_fail++; end
    n_tests++;
    if (RD2_E !== 32'h0) begin $display("FAIL wr_rd2 got %h exp 0", RD2_E); n_fail++; end
    n_tests++;
    if ({ALUControlE, ALUSrcE, flg} !== {4'd0, 1'b0, 6'b110000}) begin
      $display("FAIL wr_ctl got %h %b %b exp 0 0 110000", ALUControlE, ALUSrcE, flg); n_fail++;
    end
    n_tests++;
    if ({RD_E, RS1_E, RS2_E} !== {5'd7, 5'd5, 5'd0}) begin
      $display("FAIL wr_idx got %0d %0d %0d exp 7 5 0", RD_E, RS1_E, RS2_E); n_fail++;
    end
    n_tests++;
    if ({PCE, PCPlus4E} !== {32'h100, 32'h104}) begin
      $display("FAIL wr_pc got %h %h exp 100 104", PCE, PCPlus4E); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
    issue(32'h405280B3, 32'h104);
    RegWriteW = 1'b0;
    if ({RD1_E, RD2_E} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      $display("FAIL bypass_rd got %h %h exp deadbeef deadbeef", RD1_E, RD2_E); n_fail++;
    end
    n_tests++;
    if ({ALUControlE, RD_E} !== {4'd1, 5'd1}) begin
      $display("FAIL bypass_sub got %0d %0d exp 1 1", ALUControlE, RD_E); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_x0();
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hFFFFFFFF;
    issue(32'h000003B3, 32'h108);
    RegWriteW = 1'b0;
    if ({RD1_E, RD2_E} !== 64'h0) begin $display("FAIL x0_bypass got %h %h exp 0 0", RD1_E, RD2_E); n_fail++; end
    n_tests++;
    issue(32'h000003B3, 32'h10C);
    if (RD1_E !== 32'h0) begin $display("FAIL x0_read got %h exp 0", RD1_E); n_fail++; end
    n_tests++;
  endtask

  task automatic test_imm();
    wb(5'd2, 32'h22222222);
    wb(5'd3, 32'h33333333);
    issue(32'hFE21AE23, 32'h200); // sw x2,-4(x3)
    if (Imm_Ext_E !== 32'hFFFFFFFC) begin $display("FAIL sw_imm got %h exp fffffffc", Imm_Ext_E); n_fail++; end
    n_tests++;
    if ({flg, ALUSrcE} !== {6'b101000, 1'b1}) begin $display("FAIL sw_ctl got %b %b exp 101000 1", flg, ALUSrcE); n_fail++; end
    n_tests++;
    if ({RD1_E, RD2_E} !== {32'h33333333, 32'h22222222}) begin
      $display("FAIL sw_rd got %h %h exp 33333333 22222222", RD1_E, RD2_E); n_fail++;
    end
    n_tests++;
    issue(32'hABCDE237, 32'h204); // lui x4,0xABCDE
    if (Imm_Ext_E !== 32'hABCDE000) begin $display("FAIL lui_imm got %h exp abcde000", Imm_Ext_E); n_fail++; end
    n_tests++;
    if ({ALUControlE, ALUSrcE, flg} !== {4'd9, 1'b1, 6'b110000}) begin
      $display("FAIL lui_ctl got %0d %b %b exp 9 1 110000", ALUControlE, ALUSrcE, flg); n_fail++;
    end
    n_tests++;
    issue(32'hFF9FF0EF, 32'h208); // jal x1,-8
    if (Imm_Ext_E !== 32'hFFFFFFF8) begin $display("FAIL jal_imm got %h exp fffffff8", Imm_Ext_E); n_fail++; end
    n_tests++;
    if ({ResultSrcE, flg, RD_E} !== {2'b10, 6'b110010, 5'd1}) begin
      $display("FAIL jal_ctl got %b %b %0d exp 10 110010 1", ResultSrcE, flg, RD_E); n_fail++;
    end
    n_tests++;
    if (PCPlus4E !== 32'h20C) begin $display("FAIL jal_pc4 got %h exp 20c", PCPlus4E); n_fail++; end
    n_tests++;
    issue(32'h00208863, 32'h20C); // beq x1,x2,+16
    if ({Imm_Ext_E, ALUControlE, ALUSrcE, flg} !== {32'd16, 4'd1, 1'b0, 6'b100100}) begin
      $display("FAIL beq got %h %0d %b %b exp 10 1 0 100100", Imm_Ext_E, ALUControlE, ALUSrcE, flg); n_fail++;
    end
    n_tests++;
    issue(32'h40335293, 32'h210); // srai x5,x6,3
    if ({Imm_Ext_E, ALUControlE, ALUSrcE, flg} !== {32'h403, 4'd8, 1'b1, 6'b110000}) begin
      $display("FAIL srai got %h %0d %b %b exp 403 8 1 110000", Imm_Ext_E, ALUControlE, ALUSrcE, flg); n_fail++;
    end
    n_tests++;
    issue(32'h00812303, 32'h214); // lw x6,8(x2)
    if ({Imm_Ext_E, ResultSrcE, ALUControlE, ALUSrcE, flg} !== {32'd8, 2'b01, 4'd0, 1'b1, 6'b110000}) begin
      $display("FAIL lw got %h %b %0d %b %b exp 8 01 0 1 110000", Imm_Ext_E, ResultSrcE, ALUControlE, ALUSrcE, flg); n_fail++;
    end
    n_tests++;
    issue(32'h0000007F, 32'h218); // unknown opcode
    if (flg !== 6'b100001) begin $display("FAIL illegal_op got %b exp 100001", flg); n_fail++; end
    n_tests++;
  endtask

  task automatic test_stall_flush();
    issue(32'h00812303, 32'h300); // lw x6,8(x2), x2=22222222
    StallD = 1'b1;
    InstrD = 32'h405280B3; PCD = 32'h304; PCPlus4D = 32'h308;
    RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'h99999999;
    for (int c = 0; c < 3; c++) begin
      step();
      if ({RD1_E, Imm_Ext_E, PCE, RD_E, ResultSrcE, flg} !==
          {32'h22222222, 32'd8, 32'h300, 5'd6, 2'b01, 6'b110000}) begin
        $display("FAIL stall_hold c%0d got %h %h %h %0d %b %b", c, RD1_E, Imm_Ext_E, PCE, RD_E, ResultSrcE, flg);
        n_fail++;
      end
      n_tests++;
    end
    RegWriteW = 1'b0;
    FlushE = 1'b1;
    step();
    if ({ValidE, RegWriteE} !== 2'b00) begin $display("FAIL flush_stall got %b exp 00", {ValidE, RegWriteE}); n_fail++; end
    n_tests++;
    if (all_out !== '0) begin $display("FAIL flush_zero got %h exp 0", all_out); n_fail++; end
    n_tests++;
    FlushE = 1'b0; StallD = 1'b0;
    issue(32'h00812303, 32'h310);
    if (RD1_E !== 32'h99999999) begin $display("FAIL stall_wb_landed got %h exp 99999999", RD1_E); n_fail++; end
    n_tests++;
    InstrD = 32'h000283B3; ValidD = 1'b0;
    step();
    if (flg !== 6'b000000) begin $display("FAIL invalid_bubble got %b exp 000000", flg); n_fail++; end
    n_tests++;
    FlushE = 1'b1;
    issue(32'h000283B3, 32'h314);
    FlushE = 1'b0;
    if (flg !== 6'b000000) begin $display("FAIL flush_only got %b exp 000000", flg); n_fail++; end
    n_tests++;
  endtask

  task automatic test_rv32e();
    issue(32'h002088B3, 32'h400); // add x17,x1,x2
    if (e_flg !== 6'b100001) begin $display("FAIL rv32e_illegal got %b exp 100001", e_flg); n_fail++; end
    n_tests++;
    if (flg !== 6'b110000) begin $display("FAIL rv32i_x17_legal got %b exp 110000", flg); n_fail++; end
    n_tests++;
    wb(5'd4, 32'h44444444);
    wb(5'd20, 32'h55555555);
    issue(32'h000203B3, 32'h404); // add x7,x4,x0
    if (e_RD1_E !== 32'h44444444) begin $display("FAIL rv32e_drop got %h exp 44444444", e_RD1_E); n_fail++; end
    n_tests++;
    if (RD1_E !== 32'h44444444) begin $display("FAIL rv32i_x4 got %h exp 44444444", RD1_E); n_fail++; end
    n_tests++;
    issue(32'h000A03B3, 32'h408); // add x7,x20,x0
    if (RD1_E !== 32'h55555555) begin $display("FAIL rv32i_x20 got %h exp 55555555", RD1_E); n_fail++; end
    n_tests++;
    if (e_flg !== 6'b100001) begin $display("FAIL rv32e_rs20 got %b exp 100001", e_flg); n_fail++; end
    n_tests++;
  endtask

  initial begin
    rst = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0; ResultW = '0;
    ValidD = 1'b0; StallD = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; RDW = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_imm();
    test_stall_flush();
    test_rv32e();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
